// File: rtl/hex_digit_counter.sv
// hex_digit_counter: N-digit hex/BCD up/down counter with pushbutton load/pause and active-low 7-segment drive.
// Optional build macro BLANK_LEADING_ZEROS_EN blanks displays above the most significant non-zero digit.
module hex_digit_counter #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 50000000,
    parameter bit BCD_MODE   = 1'b0
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [1:0]              KEY,
    input  logic                    up_down,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    tick,
    output logic                    wrap,
    output logic                    paused
);
    localparam int                PRE_W     = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
    localparam logic [PRE_W-1:0]  PRE_ZERO  = PRE_W'(0);
    localparam logic [3:0]        DIGIT_MAX = BCD_MODE ? 4'd9 : 4'd15;
    localparam logic [6:0]        SEG_ZERO  = 7'h40;
`ifdef BLANK_LEADING_ZEROS_EN
    localparam logic [6:0]        LEAD_SEG  = 7'h7F;
`else
    localparam logic [6:0]        LEAD_SEG  = 7'h40;
`endif

    function automatic logic [6:0] seg_font(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    function automatic logic [7*NUM_DIGITS-1:0] hex_reset_pattern();
        logic [7*NUM_DIGITS-1:0] pat;
        pat = {(7*NUM_DIGITS){1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pat[7*i +: 7] = (i == 0) ? SEG_ZERO : LEAD_SEG;
        end
        return pat;
    endfunction

    localparam logic [7*NUM_DIGITS-1:0] HEX_RESET = hex_reset_pattern();

    logic [1:0]              key_sync1_r;
    logic [1:0]              key_sync2_r;
    logic [1:0]              key_prev_r;
    logic                    load_evt_s;
    logic                    pause_evt_s;
    logic [PRE_W-1:0]        prescale_r;
    logic                    tick_due_s;
    logic [4*NUM_DIGITS-1:0] count_r;
    logic [4*NUM_DIGITS-1:0] step_s;
    logic                    carry_s;
    logic [4*NUM_DIGITS-1:0] load_clamped_s;
    logic [7*NUM_DIGITS-1:0] hex_r;
    logic [7*NUM_DIGITS-1:0] hex_next_s;
    logic                    tick_r;
    logic                    wrap_r;
    logic                    paused_r;
`ifdef BLANK_LEADING_ZEROS_EN
    logic                    nz_seen_s;
`endif

    // Press events: released-to-pressed transition seen after the two synchroniser stages.
    always_comb begin
        load_evt_s  = key_prev_r[0] & ~key_sync2_r[0];
        pause_evt_s = key_prev_r[1] & ~key_sync2_r[1];
        tick_due_s  = ~paused_r & (prescale_r == PRE_MAX);
    end

    // Ripple step: carry (up) or borrow (down) propagates while digits sit at their limit.
    always_comb begin
        step_s  = count_r;
        carry_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry_s) begin
                if (up_down) begin
                    if (count_r[4*i +: 4] == DIGIT_MAX) begin
                        step_s[4*i +: 4] = 4'd0;
                    end else begin
                        step_s[4*i +: 4] = count_r[4*i +: 4] + 4'd1;
                        carry_s          = 1'b0;
                    end
                end else begin
                    if (count_r[4*i +: 4] == 4'd0) begin
                        step_s[4*i +: 4] = DIGIT_MAX;
                    end else begin
                        step_s[4*i +: 4] = count_r[4*i +: 4] - 4'd1;
                        carry_s          = 1'b0;
                    end
                end
            end else begin
                step_s[4*i +: 4] = count_r[4*i +: 4];
            end
        end
    end

    // Load digits, saturating anything above 9 when counting in decimal.
    always_comb begin
        load_clamped_s = load_value;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (BCD_MODE && (load_value[4*i +: 4] > 4'd9)) begin
                load_clamped_s[4*i +: 4] = 4'd9;
            end else begin
                load_clamped_s[4*i +: 4] = load_value[4*i +: 4];
            end
        end
    end

`ifdef BLANK_LEADING_ZEROS_EN
    // Segment image with displays above the top non-zero digit blanked; display 0 always lit.
    always_comb begin
        nz_seen_s  = 1'b0;
        hex_next_s = HEX_RESET;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (count_r[4*i +: 4] != 4'd0) begin
                nz_seen_s = 1'b1;
            end else begin
                nz_seen_s = nz_seen_s;
            end
            if (nz_seen_s || (i == 0)) begin
                hex_next_s[7*i +: 7] = seg_font(count_r[4*i +: 4]);
            end else begin
                hex_next_s[7*i +: 7] = LEAD_SEG;
            end
        end
    end
`else
    // Segment image: every display shows its digit.
    always_comb begin
        hex_next_s = HEX_RESET;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_next_s[7*i +: 7] = seg_font(count_r[4*i +: 4]);
        end
    end
`endif

    // Key synchroniser and edge-detect flops; reset to the released level.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_sync1_r <= 2'b11;
            key_sync2_r <= 2'b11;
            key_prev_r  <= 2'b11;
        end else begin
            key_sync1_r <= KEY;
            key_sync2_r <= key_sync1_r;
            key_prev_r  <= key_sync2_r;
        end
    end

    // Counter, prescaler, pause state and registered display; load outranks a coincident tick.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_r    <= {(4*NUM_DIGITS){1'b0}};
            prescale_r <= PRE_ZERO;
            paused_r   <= 1'b0;
            tick_r     <= 1'b0;
            wrap_r     <= 1'b0;
            hex_r      <= HEX_RESET;
        end else begin
            paused_r <= paused_r ^ pause_evt_s;
            hex_r    <= hex_next_s;
            if (load_evt_s) begin
                count_r    <= load_clamped_s;
                prescale_r <= PRE_ZERO;
                tick_r     <= 1'b0;
                wrap_r     <= 1'b0;
            end else if (tick_due_s) begin
                count_r    <= step_s;
                prescale_r <= PRE_ZERO;
                tick_r     <= 1'b1;
                wrap_r     <= carry_s;
            end else begin
                count_r    <= count_r;
                prescale_r <= paused_r ? prescale_r : (prescale_r + PRE_ONE);
                tick_r     <= 1'b0;
                wrap_r     <= 1'b0;
            end
        end
    end

    assign count  = count_r;
    assign HEX    = hex_r;
    assign tick   = tick_r;
    assign wrap   = wrap_r;
    assign paused = paused_r;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Bench for hex_digit_counter: hex and BCD instances driven in parallel, per-cycle scoreboard from an
// arithmetic reference model plus a table of segment end-states. Honours BLANK_LEADING_ZEROS_EN.
module tb_hex_digit_counter;
    localparam int ND = 4;
    localparam int TD = 4;
    localparam logic [6:0] FONT [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`ifdef BLANK_LEADING_ZEROS_EN
    localparam logic [27:0] DISP_42 = {7'h7F, 7'h7F, 7'h19, 7'h24};
    localparam logic [27:0] DISP_0  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    localparam logic [27:0] DISP_42 = {7'h40, 7'h40, 7'h19, 7'h24};
    localparam logic [27:0] DISP_0  = {7'h40, 7'h40, 7'h40, 7'h40};
`endif
    localparam logic [27:0] DISP_F  = {7'h0E, 7'h0E, 7'h0E, 7'h0E};

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [1:0]  KEY;
    logic        up_down;
    logic [15:0] load_value;
    logic [15:0] count_h, count_b;
    logic [27:0] hex_h, hex_b;
    logic        tick_h, tick_b, wrap_h, wrap_b, paused_h, paused_b;

    always #5 CLOCK_50 = ~CLOCK_50;

    hex_digit_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BCD_MODE(1'b0)) dut_hex (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY), .up_down(up_down), .load_value(load_value),
        .count(count_h), .HEX(hex_h), .tick(tick_h), .wrap(wrap_h), .paused(paused_h));

    hex_digit_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BCD_MODE(1'b1)) dut_bcd (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY), .up_down(up_down), .load_value(load_value),
        .count(count_b), .HEX(hex_b), .tick(tick_b), .wrap(wrap_b), .paused(paused_b));

    typedef struct {
        logic        rst;
        logic [1:0]  key;
        logic        ud;
        logic [15:0] lv;
        int          cycles;
        logic [15:0] exp_h;
        logic [15:0] exp_b;
        logic        exp_paused;
        logic        chk_disp;
        logic [27:0] exp_disp_h;
    } vec_t;

    typedef struct {
        logic [15:0] cnt_h;
        logic [15:0] cnt_b;
        logic [27:0] disp_h;
        logic [27:0] disp_b;
        logic        tick;
        logic        wrap_h;
        logic        wrap_b;
        logic        paused;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;

    logic [1:0]  m_s1 = 2'b11, m_s2 = 2'b11, m_s3 = 2'b11;
    int          m_pre = 0;
    logic        m_paused = 1'b0;
    logic [15:0] m_cnt_h = 16'h0000, m_cnt_b = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] disp_of(input logic [15:0] v);
        logic [27:0] d;
        int top;
        top = 0;
        for (int i = 0; i < ND; i++) if (v[4*i +: 4] != 4'd0) top = i;
        for (int i = 0; i < ND; i++) begin
            d[7*i +: 7] = FONT[v[4*i +: 4]];
`ifdef BLANK_LEADING_ZEROS_EN
            if (i > top) d[7*i +: 7] = 7'h7F;
`endif
        end
        return d;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int v;
        v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] clamp9(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = (b[4*i +: 4] > 4'd9) ? 4'd9 : b[4*i +: 4];
        return r;
    endfunction

    // Reference model: advance one clock with the currently driven inputs, queue the expected outputs.
    task automatic model_cycle();
        exp_t e;
        logic ld, pz, tk;
        int   v;
        e.tick = 1'b0; e.wrap_h = 1'b0; e.wrap_b = 1'b0;
        if (reset) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_s3 = 2'b11;
            m_pre = 0; m_paused = 1'b0; m_cnt_h = 16'h0000; m_cnt_b = 16'h0000;
            e.disp_h = disp_of(16'h0000);
            e.disp_b = disp_of(16'h0000);
        end else begin
            ld = m_s3[0] & ~m_s2[0];
            pz = m_s3[1] & ~m_s2[1];
            e.disp_h = disp_of(m_cnt_h);
            e.disp_b = disp_of(m_cnt_b);
            tk = !m_paused && (m_pre == TD - 1) && !ld;
            e.tick = tk;
            if (ld) begin
                m_cnt_h = load_value;
                m_cnt_b = clamp9(load_value);
                m_pre = 0;
            end else if (tk) begin
                m_pre = 0;
                v = from_bcd(m_cnt_b);
                if (up_down) begin
                    e.wrap_h = (m_cnt_h == 16'hFFFF);
                    m_cnt_h  = m_cnt_h + 16'd1;
                    e.wrap_b = (v == 9999);
                    m_cnt_b  = to_bcd((v + 1) % 10000);
                end else begin
                    e.wrap_h = (m_cnt_h == 16'h0000);
                    m_cnt_h  = m_cnt_h - 16'd1;
                    e.wrap_b = (v == 0);
                    m_cnt_b  = to_bcd((v + 9999) % 10000);
                end
            end else if (!m_paused) begin
                m_pre = m_pre + 1;
            end
            m_paused = m_paused ^ pz;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = KEY;
        end
        e.cnt_h = m_cnt_h; e.cnt_b = m_cnt_b; e.paused = m_paused;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL scoreboard: queue empty at cycle %0d, expected an entry", cyc);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("c%0d count_hex", cyc), 32'(count_h), 32'(e.cnt_h));
            check($sformatf("c%0d count_bcd", cyc), 32'(count_b), 32'(e.cnt_b));
            check($sformatf("c%0d HEX_hex", cyc), 32'(hex_h), 32'(e.disp_h));
            check($sformatf("c%0d HEX_bcd", cyc), 32'(hex_b), 32'(e.disp_b));
            check($sformatf("c%0d tick_hex", cyc), 32'(tick_h), 32'(e.tick));
            check($sformatf("c%0d tick_bcd", cyc), 32'(tick_b), 32'(e.tick));
            check($sformatf("c%0d wrap_hex", cyc), 32'(wrap_h), 32'(e.wrap_h));
            check($sformatf("c%0d wrap_bcd", cyc), 32'(wrap_b), 32'(e.wrap_b));
            check($sformatf("c%0d paused_hex", cyc), 32'(paused_h), 32'(e.paused));
            check($sformatf("c%0d paused_bcd", cyc), 32'(paused_b), 32'(e.paused));
        end
    endtask

    task automatic run_cycle(input logic rst, input logic [1:0] k, input logic ud, input logic [15:0] lv);
        reset = rst; KEY = k; up_down = ud; load_value = lv;
        model_cycle();
        @(posedge CLOCK_50);
        #1;
        cyc++;
        compare_out();
    endtask

    initial begin
        vec_t vt[18];
        int   n_wrap_b, n_wrap_h, n_tick;
        //          rst   key    ud    lv        cyc  exp_h     exp_b     paused chk   disp_h
        vt[0]  = '{1'b1, 2'b11, 1'b1, 16'h0000, 2,  16'h0000, 16'h0000, 1'b0, 1'b1, DISP_0};
        vt[1]  = '{1'b0, 2'b11, 1'b1, 16'h0000, 40, 16'h000A, 16'h0010, 1'b0, 1'b0, 28'h0};
        vt[2]  = '{1'b0, 2'b10, 1'b1, 16'h9999, 8,  16'h999A, 16'h0000, 1'b0, 1'b0, 28'h0};
        vt[3]  = '{1'b0, 2'b11, 1'b0, 16'h0000, 4,  16'h9999, 16'h9999, 1'b0, 1'b0, 28'h0};
        vt[4]  = '{1'b0, 2'b10, 1'b0, 16'h0000, 3,  16'h0000, 16'h0000, 1'b0, 1'b0, 28'h0};
        vt[5]  = '{1'b0, 2'b11, 1'b0, 16'h0000, 4,  16'hFFFF, 16'h9999, 1'b0, 1'b0, 28'h0};
        vt[6]  = '{1'b0, 2'b01, 1'b1, 16'hA3F5, 3,  16'hFFFF, 16'h9999, 1'b1, 1'b1, DISP_F};
        vt[7]  = '{1'b0, 2'b01, 1'b1, 16'hA3F5, 20, 16'hFFFF, 16'h9999, 1'b1, 1'b1, DISP_F};
        vt[8]  = '{1'b0, 2'b11, 1'b1, 16'hA3F5, 3,  16'hFFFF, 16'h9999, 1'b1, 1'b0, 28'h0};
        vt[9]  = '{1'b0, 2'b01, 1'b1, 16'hA3F5, 3,  16'hFFFF, 16'h9999, 1'b0, 1'b0, 28'h0};
        vt[10] = '{1'b0, 2'b11, 1'b1, 16'hA3F5, 4,  16'h0000, 16'h0000, 1'b0, 1'b0, 28'h0};
        vt[11] = '{1'b0, 2'b10, 1'b1, 16'hA3F5, 3,  16'hA3F5, 16'h9395, 1'b0, 1'b0, 28'h0};
        vt[12] = '{1'b0, 2'b11, 1'b1, 16'h0042, 5,  16'hA3F6, 16'h9396, 1'b0, 1'b0, 28'h0};
        vt[13] = '{1'b0, 2'b10, 1'b1, 16'h0042, 3,  16'h0042, 16'h0042, 1'b0, 1'b0, 28'h0};
        vt[14] = '{1'b0, 2'b11, 1'b1, 16'h0042, 2,  16'h0042, 16'h0042, 1'b0, 1'b1, DISP_42};
        vt[15] = '{1'b0, 2'b10, 1'b1, 16'h0042, 2,  16'h0043, 16'h0043, 1'b0, 1'b0, 28'h0};
        vt[16] = '{1'b1, 2'b10, 1'b1, 16'h0042, 1,  16'h0000, 16'h0000, 1'b0, 1'b1, DISP_0};
        vt[17] = '{1'b0, 2'b11, 1'b1, 16'h0042, 3,  16'h0000, 16'h0000, 1'b0, 1'b1, DISP_0};

        reset = 1'b1; KEY = 2'b11; up_down = 1'b1; load_value = 16'h0000;
        for (int r = 0; r < 18; r++) begin
            for (int c = 0; c < vt[r].cycles; c++) run_cycle(vt[r].rst, vt[r].key, vt[r].ud, vt[r].lv);
            check($sformatf("row%0d end count_hex", r), 32'(count_h), 32'(vt[r].exp_h));
            check($sformatf("row%0d end count_bcd", r), 32'(count_b), 32'(vt[r].exp_b));
            check($sformatf("row%0d end paused", r), 32'(paused_h), 32'(vt[r].exp_paused));
            if (vt[r].chk_disp) check($sformatf("row%0d end HEX_hex", r), 32'(hex_h), 32'(vt[r].exp_disp_h));
        end

        // Decimal wrap from 9999 must pulse for exactly one cycle; the hex twin goes 999A, no wrap.
        n_wrap_b = 0; n_wrap_h = 0; n_tick = 0;
        for (int c = 0; c < 12; c++) begin
            run_cycle(1'b0, (c < 3) ? 2'b10 : 2'b11, 1'b1, 16'h9999);
            n_wrap_b += int'(wrap_b);
            n_wrap_h += int'(wrap_h);
            n_tick   += int'(tick_h);
        end
        check("seq wrap_bcd pulses", 32'(n_wrap_b), 32'd1);
        check("seq wrap_hex pulses", 32'(n_wrap_h), 32'd0);
        check("seq tick pulses", 32'(n_tick), 32'd3);
        check("seq final count_bcd", 32'(count_b), 32'h0001);
        check("seq final count_hex", 32'(count_h), 32'h999B);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
